// File: rtl/sigma_boy_mash111.sv
// -----------------------------------------------------------------------------
// sigma_boy_mash111
//
// Third-order MASH 1-1-1 sigma-delta modulator for the DAC path. Three cascaded
// first-order accumulators each produce a one-bit carry. The carries are
// recombined through (1 - z^-1) and (1 - z^-1)^2 noise-cancellation networks.
// The result is a small multi-level code whose long-run mean equals x1 / 2^WIDTH.
// The quantisation noise is pushed toward high frequency.
//
// Parameters
//   WIDTH  accumulator, input and output width (minimum 4)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous, active-low reset
//   x1     in   WIDTH  unsigned input code, sampled every clock edge
//   y      out  WIDTH  two's-complement output code in -3..+4, sign-extended
//
// Build option
//   SIGMA_BOY_DITHER_EN  when defined, a 16-bit Fibonacci LFSR is added
//                        (x^16+x^14+x^13+x^11+1, seed 16'hACE1). Its bit 0 is
//                        injected as carry-in to the first accumulator. This
//                        breaks up idle tones.
// -----------------------------------------------------------------------------
module sigma_boy_mash111 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] y
);

  // Accumulator state and carry delay line
  logic [WIDTH-1:0] acc1_q, acc2_q, acc3_q;
  logic [WIDTH-1:0] acc1_d, acc2_d, acc3_d;
  logic             c2_d_q, c3_d_q, c3_dd_q;
  logic [WIDTH-1:0] y_q, y_d;

  // One bit of headroom so the MSB of each sum is the stage carry
  logic [WIDTH:0]   s1, s2, s3;
  logic             c1, c2, c3;
  logic             cin;

  // Noise-cancellation combiner: c1 + (1-z^-1)c2 + (1-z^-1)^2 c3.
  // The true result lies in -3..+4. That fits a 4-bit two's-complement value,
  // so plain modulo-16 arithmetic followed by a signed reinterpretation is exact.
  function automatic logic signed [3:0] mash_combine(
    input logic c1_i,
    input logic c2_i,
    input logic c2d_i,
    input logic c3_i,
    input logic c3d_i,
    input logic c3dd_i
  );
    logic [3:0] sum;
    sum = {3'b000, c1_i} + {3'b000, c2_i} - {3'b000, c2d_i}
        + {3'b000, c3_i} - {2'b00, c3d_i, 1'b0} + {3'b000, c3dd_i};
    return $signed(sum);
  endfunction

`ifdef SIGMA_BOY_DITHER_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        lfsr_fb;

  // Right-shifting Fibonacci form. Taps 0,2,3,5 realise x^16+x^14+x^13+x^11+1.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
  assign cin     = lfsr_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign cin = 1'b0;
`endif

  always_comb begin
    s1     = {1'b0, acc1_q} + {1'b0, x1} + {{WIDTH{1'b0}}, cin};
    c1     = s1[WIDTH];
    s2     = {1'b0, acc2_q} + {1'b0, s1[WIDTH-1:0]};
    c2     = s2[WIDTH];
    s3     = {1'b0, acc3_q} + {1'b0, s2[WIDTH-1:0]};
    c3     = s3[WIDTH];
    acc1_d = s1[WIDTH-1:0];
    acc2_d = s2[WIDTH-1:0];
    acc3_d = s3[WIDTH-1:0];
    // Size cast of a signed operand sign-extends to the full output width
    y_d    = WIDTH'(mash_combine(c1, c2, c2_d_q, c3, c3_d_q, c3_dd_q));
  end

  // Single register stage: y reflects the x1 sampled at the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc1_q  <= '0;
      acc2_q  <= '0;
      acc3_q  <= '0;
      c2_d_q  <= 1'b0;
      c3_d_q  <= 1'b0;
      c3_dd_q <= 1'b0;
      y_q     <= '0;
    end else begin
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      acc3_q  <= acc3_d;
      c2_d_q  <= c2;
      c3_d_q  <= c3;
      c3_dd_q <= c3_d_q;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_sigma_boy_mash111.sv
module tb_sigma_boy_mash111;

  localparam int WIDTH = 16;
  localparam int MOD   = 65536;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y;

  int n_chk;
  int n_err;

  // Behavioural reference state (integer arithmetic)
  int m_a1, m_a2, m_a3;
  int m_c2d, m_c3d, m_c3dd;

  sigma_boy_mash111 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x1    (x1),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_a1 = 0; m_a2 = 0; m_a3 = 0;
    m_c2d = 0; m_c3d = 0; m_c3dd = 0;
  endtask

  task automatic model_step(input int x, output int yv);
    int s1, s2, s3, k1, k2, k3;
    s1 = m_a1 + x;  k1 = s1 / MOD;  m_a1 = s1 % MOD;
    s2 = m_a2 + m_a1; k2 = s2 / MOD; m_a2 = s2 % MOD;
    s3 = m_a3 + m_a2; k3 = s3 / MOD; m_a3 = s3 % MOD;
    yv = k1 + k2 - m_c2d + k3 - 2 * m_c3d + m_c3dd;
    m_c3dd = m_c3d;
    m_c3d  = k3;
    m_c2d  = k2;
  endtask

  function automatic logic [15:0] to_code(input int v);
    logic [31:0] t;
    t = v;
    return t[15:0];
  endfunction

  function automatic int as_int(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  logic [15:0] pat8000 [4];

  initial begin
    int yv, sum, msum, viol;
    logic [15:0] xv;
    n_chk = 0;
    n_err = 0;
    pat8000[0] = 16'h0000; pat8000[1] = 16'h0002;
    pat8000[2] = 16'hFFFF; pat8000[3] = 16'h0001;
    rst_n = 1'b0;
    x1 = '0;
    model_reset();
    #2;
    chk("reset_y", y, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SIGMA_BOY_DITHER_EN
    // Dithered build: mean of y at quarter scale and LFSR liveness
    begin
      int zeros;
      sum = 0; zeros = 0;
      x1 = 16'h4000;
      for (int i = 0; i < 65536; i++) begin
        tick();
        sum += as_int(y);
        if (dut.lfsr_q == 16'h0000) zeros++;
      end
      chk("dith_mean", (sum >= 16384 - 2 && sum <= 16384 + 2), 1);
      chk("dith_lfsr_zero", zeros, 0);
    end
`else
    // x1 = 0: y must stay 0
    x1 = 16'h0000;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("zero_in", y, 16'h0000);
    end

    // Half scale: 0000, 0002, FFFF, 0001 repeating
    do_reset();
    x1 = 16'h8000;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("half_c%0d", i + 1), y, pat8000[i % 4]);
    end

    // Asynchronous reset between edges, mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y",    y,           16'h0000);
    chk("arst_acc1", dut.acc1_q,  16'h0000);
    chk("arst_acc2", dut.acc2_q,  16'h0000);
    chk("arst_acc3", dut.acc3_q,  16'h0000);
    chk("arst_dly",  {dut.c2_d_q, dut.c3_d_q, dut.c3_dd_q}, 3'b000);
    tick();
    chk("arst_hold_y", y, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("arst_restart_c%0d", i + 1), y, pat8000[i % 4]);
    end

    // Smallest nonzero input over a full accumulator period
    do_reset();
    x1 = 16'h0001;
    sum = 0; msum = 0; viol = 0;
    for (int i = 0; i < 65536; i++) begin
      model_step(1, yv);
      tick();
      sum  += as_int(y);
      msum += yv;
      if (as_int(y) < -3 || as_int(y) > 4) viol++;
    end
    chk("lsb_sum_model", sum, msum);
    chk("lsb_sum_near1", (sum >= 0 && sum <= 2), 1);
    chk("lsb_range", viol, 0);

    // Bring-up walk: 1..8, each held two cycles; no carries yet, so y stays 0
    do_reset();
    for (int v = 1; v <= 8; v++) begin
      for (int r = 0; r < 2; r++) begin
        x1 = 16'(v);
        model_step(v, yv);
        tick();
        chk($sformatf("walk_x%0d_r%0d", v, r), y, 16'h0000);
        chk($sformatf("walk_model_x%0d_r%0d", v, r), y, to_code(yv));
      end
    end

    // Full-scale input against the reference model
    do_reset();
    x1 = 16'hFFFF;
    viol = 0;
    for (int i = 0; i < 64; i++) begin
      model_step(65535, yv);
      tick();
      chk($sformatf("full_c%0d", i + 1), y, to_code(yv));
      if (as_int(y) < -3 || as_int(y) > 4) viol++;
    end
    chk("full_range", viol, 0);

    // Input changing every cycle, without a reset in between
    viol = 0;
    for (int i = 0; i < 400; i++) begin
      xv = 16'($urandom_range(0, 65535));
      x1 = xv;
      model_step(int'(xv), yv);
      tick();
      chk($sformatf("rand_c%0d", i), y, to_code(yv));
      if (as_int(y) < -3 || as_int(y) > 4) viol++;
    end
    chk("rand_range", viol, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
